operand_load_ctrl: RTL and testbench
====================================

Name: operand_load_ctrl

Overview:
Sequencer that owns the single-address port of the operand register bank (MAX_DIM x MAX_DIM elements of DATA_WIDTH). It accepts matrix rows as packed BUS_WIDTH words over a valid/ready handshake and unpacks each row into one element write per cycle. Once the configured dim x dim operand is loaded, it streams the elements back out in row-major order to the compute engine over a second valid/ready handshake, then pulses done. It sits between the bus-side operand interface and the operand bank.

Parameters:
DATA_WIDTH, 32, element width
BUS_WIDTH, 64, row word width; carries MAX_DIM packed elements
ADDR_WIDTH, 32, operand bank address width
MAX_DIM, BUS_WIDTH/DATA_WIDTH, maximum matrix dimension (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  begin a load/stream operation (sampled in IDLE only)
dim_i  in  ADDR_WIDTH  matrix dimension, sampled on accepted start
row_valid_i  in  1  row word valid
row_data_i  in  BUS_WIDTH  row word; element j in bits [j*DATA_WIDTH +: DATA_WIDTH]
row_ready_o  out  1  controller can accept a row
mem_we_o  out  1  operand bank write enable
mem_addr_o  out  ADDR_WIDTH  operand bank address (read and write)
mem_wdata_o  out  DATA_WIDTH  operand bank write data
mem_rdata_i  in  DATA_WIDTH  operand bank asynchronous read data
out_valid_o  out  1  element valid toward engine
out_data_o  out  DATA_WIDTH  element toward engine
out_ready_i  in  1  engine accepts element
busy_o  out  1  high in any state other than IDLE
done_o  out  1  single-cycle completion pulse

Behaviour:
- One clock, clk_i; reset is asynchronous and active-low on rst_ni. Reset forces IDLE, all counters to 0, row buffer to 0; every output is 0 during and after reset.
- States: IDLE, CLEAR (optional feature only), LOAD_WAIT, LOAD_WR, STREAM, DONE.
- IDLE: on start_i=1, latch dim. dim_i=0 or dim_i>MAX_DIM is latched as MAX_DIM. Next state is LOAD_WAIT (or CLEAR when the feature is compiled in). start_i outside IDLE is ignored.
- LOAD_WAIT: row_ready_o=1. Handshake occurs on the edge where row_valid_i && row_ready_o: capture row_data_i into the row buffer, set col=0, go to LOAD_WR. row_ready_o=0 in every other state.
- LOAD_WR: for each col in 0..dim-1, one write per cycle: mem_we_o=1, mem_addr_o=row*MAX_DIM+col, mem_wdata_o=buffer[col]. The first write occurs in the cycle after the handshake.
  - After col=dim-1: if row<dim-1, increment row and return to LOAD_WAIT.
  - Otherwise reset row and col to 0 and go to STREAM.
  - Elements with index >= dim in a row word are discarded.
- STREAM: mem_we_o=0, mem_addr_o=r*MAX_DIM+c, out_valid_o=1, out_data_o=mem_rdata_i (combinational, zero latency).
  - On out_valid_o && out_ready_i, advance c; wrap c to 0 and increment r at c=dim-1.
  - On acceptance of element (dim-1,dim-1), go to DONE.
  - out_valid_o stays high and data stays stable while out_ready_i=0.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o=0 in DONE and IDLE.
- When mem_we_o=0, mem_wdata_o=0. Outside LOAD_WR, STREAM and CLEAR, mem_addr_o=0.
- Reset mid-operation aborts immediately. Partially written bank contents are left as-is; the bank has its own reset.
- Address arithmetic is done in ADDR_WIDTH bits; no overflow is possible since the maximum index is MAX_DIM*MAX_DIM-1.

Optional Feature:
- Macro OPERAND_LOAD_CTRL_CLEAR_EN.
- Defined: after an accepted start, the CLEAR state writes 0 to all MAX_DIM*MAX_DIM addresses, one per cycle in ascending order (mem_we_o=1, mem_wdata_o=0), then enters LOAD_WAIT. This guarantees that unused entries (row or col >= dim) read as 0 for the engine. busy_o=1 during CLEAR.
- Not defined: the CLEAR state does not exist; IDLE goes directly to LOAD_WAIT and unused entries keep their previous values.

Test Plan:
- Reset: hold rst_ni=0 with start_i=1 and row_valid_i=1 -> all outputs 0, state stays IDLE; release -> still idle until start_i is sampled.
- Full 2x2 load and stream: start, dim=2; rows 64'h00000002_00000001 then 64'h00000004_00000003 with a compliant bank -> writes (addr 0..3) = 1,2,3,4, one per cycle; stream yields 1,2,3,4; done_o pulses once.
- Backpressure: same load, out_ready_i toggled 0,0,1,0,1,1,1 -> each element is held stable while stalled, no element is duplicated or skipped, done_o follows the 4th acceptance.
- dim=1 with row 64'hDEADBEEF_00000011 -> single write 32'h11 to addr 0; upper element discarded; stream emits one element 32'h11, then done_o.
- dim_i=0 and dim_i=7 -> both behave as dim=2 (four writes, four stream elements).
- With OPERAND_LOAD_CTRL_CLEAR_EN defined, dim=1 after a prior 2x2 load of 1..4 -> four zero writes, then a write of addr 0; bank holds {v,0,0,0}. Without the macro, addr 1..3 keep 2,3,4. Also assert rst_ni low during LOAD_WR -> immediate IDLE with outputs 0.

Source files
------------

// File: rtl/operand_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// operand_load_ctrl_if
//
// Bundles every non-clock signal of the operand load controller: the start
// and dimension controls, the bus-side row handshake, the operand-bank
// single-address port and the element stream toward the compute engine.
//
// Modports:
//   slave  - the controller itself (consumes start/rows/read data/ready,
//            produces row_ready, bank write/address, stream, busy, done)
//   master - the environment around the controller (bus, bank, engine)
// ---------------------------------------------------------------------------
interface operand_load_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 64,
   parameter int ADDR_WIDTH = 32
);
   logic                  start_i;
   logic [ADDR_WIDTH-1:0] dim_i;
   logic                  row_valid_i;
   logic [BUS_WIDTH-1:0]  row_data_i;
   logic                  row_ready_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  out_valid_o;
   logic [DATA_WIDTH-1:0] out_data_o;
   logic                  out_ready_i;
   logic                  busy_o;
   logic                  done_o;

   modport slave (
      input  start_i, dim_i, row_valid_i, row_data_i, mem_rdata_i, out_ready_i,
      output row_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
             out_valid_o, out_data_o, busy_o, done_o
   );

   modport master (
      output start_i, dim_i, row_valid_i, row_data_i, mem_rdata_i, out_ready_i,
      input  row_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
             out_valid_o, out_data_o, busy_o, done_o
   );
endinterface

// File: rtl/operand_load_ctrl.sv
// ---------------------------------------------------------------------------
// operand_load_ctrl
//
// Owns the single-address port of the operand bank. Accepts dim rows as
// packed BUS_WIDTH words, unpacks each into one element write per cycle,
// then streams the dim x dim operand back out row-major (bank read data is
// forwarded combinationally) and pulses done for one cycle.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   bus     - operand_load_ctrl_if.slave: start/dim, row handshake,
//             bank port, element stream, busy/done
//
// Configuration macro:
//   OPERAND_LOAD_CTRL_CLEAR_EN - when defined, every accepted start first
//   zeroes all MAX_DIM*MAX_DIM bank entries (CLEAR state) before loading.
// ---------------------------------------------------------------------------
module operand_load_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 64,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   operand_load_ctrl_if.slave  bus
);

   localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH;
   localparam int NUM_ELEMS = MAX_DIM * MAX_DIM;

   localparam logic [ADDR_WIDTH-1:0] MAX_DIM_A = ADDR_WIDTH'(MAX_DIM);
`ifdef OPERAND_LOAD_CTRL_CLEAR_EN
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ELEMS - 1);
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
`ifdef OPERAND_LOAD_CTRL_CLEAR_EN
      CLEAR     = 3'd1,
`endif
      LOAD_WAIT = 3'd2,
      LOAD_WR   = 3'd3,
      STREAM    = 3'd4,
      DONE      = 3'd5
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] dim;
   logic [ADDR_WIDTH-1:0] row;
   logic [ADDR_WIDTH-1:0] col;
   logic [BUS_WIDTH-1:0]  row_buf;

   // Registered copies of the outputs; each is loaded with the value the
   // next state needs, so every transition below also sets the outputs.
   logic                  row_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  out_valid;
   logic                  busy;
   logic                  done;

   // Out-of-range dimensions (0 or larger than a row word holds) saturate.
   logic [ADDR_WIDTH-1:0] dim_eff;
   assign dim_eff = (bus.dim_i == '0 || bus.dim_i > MAX_DIM_A) ? MAX_DIM_A : bus.dim_i;

   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] r,
                                                     input logic [ADDR_WIDTH-1:0] c);
      return r * MAX_DIM_A + c;
   endfunction

   // Element select written as a compare loop so every slice is constant.
   function automatic logic [DATA_WIDTH-1:0] elem(input logic [BUS_WIDTH-1:0]  word,
                                                  input logic [ADDR_WIDTH-1:0] idx);
      logic [DATA_WIDTH-1:0] e;
      e = '0;
      for (int j = 0; j < MAX_DIM; j++) begin
         if (idx == ADDR_WIDTH'(j)) e = word[j*DATA_WIDTH +: DATA_WIDTH];
      end
      return e;
   endfunction

   // NOTE: all state and output registers use non-blocking assignments so
   // every transition reads the pre-edge values of row/col/mem_addr.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         dim       <= '0;
         row       <= '0;
         col       <= '0;
         // NOTE: the row buffer is a single register, not a memory array,
         // so clearing it on reset is cheap and keeps the state deterministic.
         row_buf   <= '0;
         row_ready <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  dim  <= dim_eff;
                  row  <= '0;
                  col  <= '0;
                  busy <= 1'b1;
`ifdef OPERAND_LOAD_CTRL_CLEAR_EN
                  mem_we    <= 1'b1;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  state     <= CLEAR;
`else
                  row_ready <= 1'b1;
                  state     <= LOAD_WAIT;
`endif
               end
            end

`ifdef OPERAND_LOAD_CTRL_CLEAR_EN
            CLEAR: begin
               // mem_addr doubles as the sweep counter; wdata is already 0.
               if (mem_addr == LAST_ADDR) begin
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  row_ready <= 1'b1;
                  state     <= LOAD_WAIT;
               end else begin
                  mem_addr <= mem_addr + 1'b1;
               end
            end
`endif

            LOAD_WAIT: begin
               // row_ready is high throughout this state.
               if (bus.row_valid_i) begin
                  row_buf   <= bus.row_data_i;
                  col       <= '0;
                  row_ready <= 1'b0;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_of(row, '0);
                  mem_wdata <= bus.row_data_i[DATA_WIDTH-1:0];
                  state     <= LOAD_WR;
               end
            end

            LOAD_WR: begin
               if (col == dim - 1'b1) begin
                  col       <= '0;
                  mem_we    <= 1'b0;
                  mem_wdata <= '0;
                  mem_addr  <= '0;
                  if (row != dim - 1'b1) begin
                     row       <= row + 1'b1;
                     row_ready <= 1'b1;
                     state     <= LOAD_WAIT;
                  end else begin
                     // First stream address is 0, already loaded above.
                     row       <= '0;
                     out_valid <= 1'b1;
                     state     <= STREAM;
                  end
               end else begin
                  col       <= col + 1'b1;
                  mem_addr  <= addr_of(row, col + 1'b1);
                  mem_wdata <= elem(row_buf, col + 1'b1);
               end
            end

            STREAM: begin
               // out_valid is high throughout this state; hold the address
               // (and hence the read data) until the engine accepts.
               if (bus.out_ready_i) begin
                  if (col == dim - 1'b1) begin
                     col <= '0;
                     if (row == dim - 1'b1) begin
                        row       <= '0;
                        out_valid <= 1'b0;
                        mem_addr  <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                     end else begin
                        row      <= row + 1'b1;
                        mem_addr <= addr_of(row + 1'b1, '0);
                     end
                  end else begin
                     col      <= col + 1'b1;
                     mem_addr <= addr_of(row, col + 1'b1);
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.row_ready_o = row_ready;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_wdata_o = mem_wdata;
   assign bus.out_valid_o = out_valid;
   // Gated so the stream output reads 0 whenever no element is offered.
   assign bus.out_data_o  = out_valid ? bus.mem_rdata_i : '0;
   assign bus.busy_o      = busy;
   assign bus.done_o      = done;

endmodule

// File: tb/tb_operand_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_operand_load_ctrl
//
// Scoreboard bench for operand_load_ctrl. A small operand bank model is
// attached to the bank port. Each operation pushes its expected bank writes
// and stream elements into queues computed from the loaded matrix; a
// negedge monitor pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_operand_load_ctrl;

   localparam int DW = 32;
   localparam int BW = 64;
   localparam int AW = 32;
   localparam int MD = BW / DW;
   localparam int NE = MD * MD;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk;
   logic rst_n;

   operand_load_ctrl_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

   operand_load_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Operand bank: synchronous write, asynchronous read.
   logic [DW-1:0] bank [NE];
   always @(posedge clk) begin
      if (bus.mem_we_o && bus.mem_addr_o < NE) bank[bus.mem_addr_o[1:0]] <= bus.mem_wdata_o;
   end
   assign bus.mem_rdata_i = (bus.mem_addr_o < NE) ? bank[bus.mem_addr_o[1:0]] : '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int done_cnt = 0;

   wr_t           exp_wr [$];
   logic [DW-1:0] exp_out [$];
   logic [DW-1:0] model_bank [NE];

   int ready_mode = 1;  // 0 random, 1 always ready, 2 fixed pattern
   int pat_idx    = 0;
   int pat [7]    = '{0, 0, 1, 0, 1, 1, 1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else pass_cnt++;
   endtask

   // Monitor: compares every bank write and every offered stream element.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.mem_we_o) begin
               if (exp_wr.size() == 0) begin
                  check("unexpected_write", 1, 0);
               end else begin
                  check("wr_addr", bus.mem_addr_o, exp_wr[0].addr);
                  check("wr_data", bus.mem_wdata_o, exp_wr[0].data);
                  void'(exp_wr.pop_front());
               end
            end
            if (bus.out_valid_o) begin
               if (exp_out.size() == 0) begin
                  check("unexpected_out", 1, 0);
               end else begin
                  check("out_data", bus.out_data_o, exp_out[0]);
                  if (bus.out_ready_i) void'(exp_out.pop_front());
               end
            end
            if (bus.done_o) done_cnt++;
         end
      end
   end

   // Engine-side ready driver.
   initial begin
      bus.out_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: bus.out_ready_i = 1'($urandom_range(0, 1));
            2: begin
               if (bus.out_valid_o && pat_idx < 7) begin
                  bus.out_ready_i = pat[pat_idx] != 0;
                  pat_idx++;
               end else begin
                  bus.out_ready_i = bus.out_valid_o;
               end
            end
            default: bus.out_ready_i = 1'b1;
         endcase
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_row_ready"}, bus.row_ready_o, 0);
      check({tag, "_mem_we"},    bus.mem_we_o,    0);
      check({tag, "_mem_addr"},  bus.mem_addr_o,  0);
      check({tag, "_mem_wdata"}, bus.mem_wdata_o, 0);
      check({tag, "_out_valid"}, bus.out_valid_o, 0);
      check({tag, "_out_data"},  bus.out_data_o,  0);
      check({tag, "_busy"},      bus.busy_o,      0);
      check({tag, "_done"},      bus.done_o,      0);
   endtask

   // Leaves the caller at posedge+1 with reset released.
   task automatic recover_reset();
      rst_n = 1'b0;
      bus.start_i = 1'b0;
      bus.row_valid_i = 1'b0;
      exp_wr.delete();
      exp_out.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic push_clear();
`ifdef OPERAND_LOAD_CTRL_CLEAR_EN
      for (int a = 0; a < NE; a++) begin
         wr_t w;
         w.addr = AW'(a);
         w.data = '0;
         exp_wr.push_back(w);
         model_bank[a] = '0;
      end
`endif
   endtask

   // Sends one row word; returns 1 when the handshake took place.
   task automatic send_row(input logic [BW-1:0] word, input int gap, output bit ok);
      ok = 0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.row_valid_i = 1'b1;
      bus.row_data_i  = word;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (bus.row_ready_o) ok = 1;
         @(posedge clk);
         #1;
      end
      bus.row_valid_i = 1'b0;
      bus.row_data_i  = {$urandom, $urandom};
      if (!ok) check("row_handshake_timeout", 0, 1);
   endtask

   // One full load/stream operation; called at posedge+1.
   task automatic run_op(input logic [AW-1:0] dim_in, input logic [BW-1:0] r0,
                         input logic [BW-1:0] r1, input int rmode, input bit noisy);
      int            d;
      int            done_before;
      bit            ok;
      bit            got_done;
      logic [BW-1:0] rows [MD];
      rows[0] = r0;
      rows[1] = r1;
      d = (dim_in == 0 || dim_in > MD) ? MD : int'(dim_in);

      push_clear();
      for (int r = 0; r < d; r++) begin
         for (int c = 0; c < d; c++) begin
            wr_t w;
            w.addr = AW'(r * MD + c);
            w.data = rows[r][c*DW +: DW];
            exp_wr.push_back(w);
            model_bank[r * MD + c] = w.data;
         end
      end
      for (int r = 0; r < d; r++)
         for (int c = 0; c < d; c++) exp_out.push_back(model_bank[r * MD + c]);

      ready_mode  = rmode;
      pat_idx     = 0;
      done_before = done_cnt;

      bus.start_i = 1'b1;
      bus.dim_i   = dim_in;
      @(posedge clk);
      #1;
      bus.start_i = noisy;
      bus.dim_i   = $urandom;
      check("busy_after_start", bus.busy_o, 1);

      ok = 1;
      for (int r = 0; r < d && ok; r++) send_row(rows[r], noisy ? $urandom_range(0, 3) : 0, ok);
      bus.start_i = 1'b0;

      got_done = 0;
      for (int n = 0; n < 300 && ok && !got_done; n++) begin
         @(posedge clk);
         #1;
         if (done_cnt != done_before) got_done = 1;
      end
      if (!got_done) begin
         check("done_timeout", 0, 1);
         recover_reset();
      end else begin
         repeat (3) begin
            @(posedge clk);
            #1;
         end
         check("done_once", done_cnt - done_before, 1);
         check("writes_drained", exp_wr.size(), 0);
         check("stream_drained", exp_out.size(), 0);
         check("busy_after_done", bus.busy_o, 0);
         for (int a = 0; a < NE; a++) check($sformatf("bank_%0d", a), bank[a], model_bank[a]);
      end
      ready_mode = 1;
   endtask

   // Reset asserted during the first write of a load.
   task automatic abort_op();
      bit ok;
      bit seen;
      wr_t w;
      push_clear();
      w.addr = '0;
      w.data = 32'hA5A5_0001;
      exp_wr.push_back(w);
      bus.start_i = 1'b1;
      bus.dim_i   = AW'(2);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      send_row(64'h0000_0002_A5A5_0001, 0, ok);
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (bus.mem_we_o) seen = 1;
      end
      check("abort_reached_load_wr", seen, 1);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("abort");
      exp_wr.delete();
      exp_out.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check_idle_outputs("after_abort");
   endtask

   initial begin
      for (int a = 0; a < NE; a++) begin
         bank[a]       = '0;
         model_bank[a] = '0;
      end
      rst_n = 1'b0;
      bus.start_i     = 1'b1;
      bus.dim_i       = AW'(2);
      bus.row_valid_i = 1'b1;
      bus.row_data_i  = {$urandom, $urandom};

      repeat (3) @(posedge clk);
      #2 check_idle_outputs("in_reset");
      @(posedge clk);
      #1;
      bus.start_i     = 1'b0;
      bus.row_valid_i = 1'b0;
      rst_n           = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_idle_outputs("post_reset");

      // Directed cases.
      run_op(AW'(2), 64'h0000_0002_0000_0001, 64'h0000_0004_0000_0003, 1, 0);
      run_op(AW'(1), 64'hDEAD_BEEF_0000_0011, 64'h0, 1, 0);
      run_op(AW'(2), 64'h0000_0002_0000_0001, 64'h0000_0004_0000_0003, 2, 0);
      run_op(AW'(0), 64'h0000_0020_0000_0010, 64'h0000_0040_0000_0030, 1, 0);
      run_op(AW'(7), 64'h0000_0200_0000_0100, 64'h0000_0400_0000_0300, 0, 0);
      abort_op();

      // Randomized operations.
      for (int i = 0; i < 24; i++) begin
         logic [AW-1:0] dv;
         case ($urandom_range(0, 4))
            0: dv = '0;
            1: dv = AW'(1);
            2: dv = AW'(2);
            3: dv = AW'($urandom_range(3, 7));
            default: dv = $urandom | 32'h8000_0000;
         endcase
         run_op(dv, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1), 1);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
